apb_reg_slave: RTL and testbench
================================

// Module: apb_reg_slave
// PURPOSE
//  APB3 completer (responder) end of the apb_if bus: decodes one psel bit, serves a bank of
//  32-bit registers with programmable wait states and pslverr on bad accesses.
//  Sits behind the APB interconnect as the DUT-side counterpart of the APB UVC master agent.
//  Exposes register contents and per-register write strobes to the local hardware.
// PARAMETERS
//  ADDR_WIDTH   32          paddr width
//  DATA_WIDTH   32          pwdata/prdata width (must be 32)
//  NUM_REGS     16          register count, 1..256; word-aligned, contiguous from BASE_ADDR
//  BASE_ADDR    'h0         byte address of register 0
//  WAIT_STATES  0           pready-low cycles inserted in every access phase, 0..15
//  RO_MASK      '0          bit i=1: reg i is read-only; reads return hw_rdata_i slice i
// PORTS
//  pclk         in   1                      APB clock, all logic on rising edge
//  presetn      in   1                      asynchronous, active-low reset
//  paddr        in   ADDR_WIDTH             byte address
//  psel         in   1                      this completer's select
//  penable      in   1                      access phase marker
//  pwrite       in   1                      1=write, 0=read
//  pwdata       in   DATA_WIDTH             write data
//  prdata       out  DATA_WIDTH             read data, valid only when pready=1 for a read
//  pready       out  1                      transfer complete
//  pslverr      out  1                      error response, qualified by pready
//  hw_rdata_i   in   NUM_REGS*DATA_WIDTH    read values for RO registers
//  regs_o       out  NUM_REGS*DATA_WIDTH    current RW register contents (RO slots drive 0)
//  wr_pulse_o   out  NUM_REGS               1-cycle strobe, bit i on successful write to reg i
// BEHAVIOUR
//  Reset: state=IDLE, all RW regs=0, prdata=0, pready=0, pslverr=0, wr_pulse_o=0, counter=0.
//  FSM IDLE/ACCESS:
//   IDLE: psel=1 & penable=0 (setup) -> latch paddr/pwrite/pwdata, load cnt=WAIT_STATES,
//         compute err, go ACCESS. psel=1 & penable=1 in IDLE is ignored (no response).
//   ACCESS: psel=1 & penable=1: cnt!=0 -> cnt--, pready=0; cnt==0 -> pready=1 (comb.),
//         complete, go IDLE. Min transfer = 2 cycles (setup+access) with WAIT_STATES=0.
//   ACCESS abort: psel=0, or penable=0 -> go IDLE, no write, no strobe; if psel=1&penable=0
//         the cycle is re-decoded as a fresh setup (back to ACCESS, new latch).
//  Decode: offset=paddr-BASE_ADDR (ADDR_WIDTH-bit, wrap ignored); idx=offset>>2.
//   err=1 if offset[1:0]!=0, paddr<BASE_ADDR, idx>=NUM_REGS, or write to RO_MASK reg.
//  Completion cycle (pready=1): pslverr=err; write & !err -> reg[idx]<=pwdata at edge,
//   wr_pulse_o[idx]=1 the following cycle for exactly 1 cycle; err write -> no change.
//   Read & !err -> prdata = RO ? hw_rdata_i[idx] : reg[idx] (sampled that cycle); err -> 0.
//  pready, pslverr, prdata are 0 in every non-completion cycle.
//  Back-to-back: new setup accepted in the cycle after completion (IDLE).
//  Reset asserted mid-transfer: immediate return to reset values; transfer is lost.
// STRUCTURE
//  apb_reg_pkg: state_t enum {IDLE, ACCESS}, IDX_W=$clog2(NUM_REGS) helper, WORD_BYTES=4.
//  One sub-module apb_wait_ctr: loadable down-counter with zero flag (cnt/load/dec/zero).
//  Top holds FSM, decode, register array, read mux, strobe register.
// TESTING
//  W=0: write 0x100C<-0xDEADBEEF (BASE=0x1000) -> pready at cycle 2, pslverr=0,
//   wr_pulse_o[3] 1 cycle; read 0x100C -> prdata=0xDEADBEEF.
//  W=3: read reg 0 -> pready low 3 access cycles, high on 4th; total 5 cycles.
//  Errors: paddr=0x1002, 0x1040 (NUM_REGS=16), 0x0FFC, write to RO reg 2 ->
//   pslverr=1, prdata=0, regs unchanged, no wr_pulse.
//  RO read: RO_MASK=0x4, hw_rdata_i slot2=0x12345678 -> read 0x1008 returns 0x12345678.
//  Abort: W=4, drop psel after 2 access cycles on write -> no update; next read gets old value.
//  presetn low mid-wait then high -> all outputs 0, regs 0, next transfer completes normally.

Source files
------------

// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB register completer.
package apb_reg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  // Register index width, never narrower than one bit so a single-register bank still has an index
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter that paces the wait states of one APB access phase.
module apb_wait_ctr
  import apb_reg_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Count register: load takes priority, decrement saturates at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 completer serving a bank of 32-bit registers with fixed wait states,
// read-only slots fed by local hardware, and per-register write strobes.
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W = idx_w(NUM_REGS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;

  logic                  w_setup;
  logic                  w_access;
  logic                  w_load;
  logic                  w_dec;
  logic                  w_complete;
  logic                  w_zero;
  logic [CNT_W-1:0]      w_cnt;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_idx_new;
  logic                  w_idx_ok;
  logic                  w_err_new;
  logic                  w_do_write;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_setup  = psel && !penable;
  assign w_access = psel && penable;

  apb_wait_ctr #(.W(CNT_W)) u_wait_ctr (
    .i_clk      (pclk),
    .i_rst_n    (presetn),
    .i_load     (w_load),
    .i_load_val (CNT_W'(WAIT_STATES)),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  // Address decode of the setup-phase address; offset wrap below the base is caught separately
  always_comb begin
    w_offset  = paddr - BASE_ADDR;
    w_word    = w_offset >> 2;
    w_idx_ok  = (w_word < ADDR_WIDTH'(NUM_REGS));
    w_idx_new = w_word[IDX_W-1:0];
    w_err_new = 1'b0;
    if ((w_offset[1:0] != 2'b00) || (paddr < BASE_ADDR) || !w_idx_ok) begin
      w_err_new = 1'b1;
    end else if (pwrite && RO_MASK[w_idx_new]) begin
      w_err_new = 1'b1;
    end else begin
      w_err_new = 1'b0;
    end
  end

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a setup seen in ACCESS (abort) is re-decoded as a fresh transfer
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_load      = 1'b1;
          w_state_nxt = ACCESS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (w_access) begin
          if (w_zero) begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_dec       = 1'b1;
            w_state_nxt = ACCESS;
          end
        end else if (w_setup) begin
          w_load      = 1'b1;
          w_state_nxt = ACCESS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Transfer attributes captured at setup
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_write <= 1'b0;
      r_wdata <= {DATA_WIDTH{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_err   <= 1'b0;
    end else if (w_load) begin
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_idx   <= w_idx_new;
      r_err   <= w_err_new;
    end else begin
      r_write <= r_write;
      r_wdata <= r_wdata;
      r_idx   <= r_idx;
      r_err   <= r_err;
    end
  end

  assign w_do_write = w_complete && r_write && !r_err;

  // Register bank; RO slots are never written because such writes decode as errors
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_do_write) begin
      r_regs[r_idx] <= r_wdata;
    end else begin
      r_regs <= r_regs;
    end
  end

  // Write strobe, one cycle after the completing edge
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wr_pulse <= {NUM_REGS{1'b0}};
    end else if (w_do_write) begin
      r_wr_pulse <= NUM_REGS'(1) << r_idx;
    end else begin
      r_wr_pulse <= {NUM_REGS{1'b0}};
    end
  end

  // Read mux, sampled live in the completion cycle
  always_comb begin
    if (RO_MASK[r_idx]) begin
      w_rd_data = hw_rdata_i[r_idx*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      w_rd_data = r_regs[r_idx];
    end
  end

  assign pready     = w_complete;
  assign pslverr    = w_complete && r_err;
  assign prdata     = (w_complete && !r_write && !r_err) ? w_rd_data : {DATA_WIDTH{1'b0}};
  assign wr_pulse_o = r_wr_pulse;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? {DATA_WIDTH{1'b0}} : r_regs[g];
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench: three completers (0, 3 and 4 wait states) on one shared APB bus.
module tb_apb_reg_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [15:0] RO   = 16'h0004;

  logic         pclk = 1'b0;
  logic         presetn;
  logic [31:0]  paddr;
  logic [2:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [511:0] hw_rdata;
  logic [31:0]  prdata_a   [3];
  logic         pready_a   [3];
  logic         pslverr_a  [3];
  logic [511:0] regs_a     [3];
  logic [15:0]  wr_pulse_a [3];

  int          n_pass = 0;
  int          n_total = 0;
  int          ws [3] = '{0, 3, 4};
  logic [31:0] mem [3][16];

  always #5 pclk = ~pclk;

  apb_reg_slave #(.NUM_REGS(16), .BASE_ADDR(BASE), .WAIT_STATES(0), .RO_MASK(RO)) u_d0 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_a[0]), .pready(pready_a[0]),
    .pslverr(pslverr_a[0]), .hw_rdata_i(hw_rdata), .regs_o(regs_a[0]), .wr_pulse_o(wr_pulse_a[0]));
  apb_reg_slave #(.NUM_REGS(16), .BASE_ADDR(BASE), .WAIT_STATES(3), .RO_MASK(RO)) u_d1 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_a[1]), .pready(pready_a[1]),
    .pslverr(pslverr_a[1]), .hw_rdata_i(hw_rdata), .regs_o(regs_a[1]), .wr_pulse_o(wr_pulse_a[1]));
  apb_reg_slave #(.NUM_REGS(16), .BASE_ADDR(BASE), .WAIT_STATES(4), .RO_MASK(RO)) u_d2 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_a[2]), .pready(pready_a[2]),
    .pslverr(pslverr_a[2]), .hw_rdata_i(hw_rdata), .regs_o(regs_a[2]), .wr_pulse_o(wr_pulse_a[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference rules: alignment, range, below-base, write to read-only slot
  function automatic bit ref_err(input logic [31:0] addr, input bit wr);
    logic [31:0] off;
    if (addr < BASE) return 1'b1;
    off = addr - BASE;
    if (off % 4 != 0) return 1'b1;
    if (off / 4 >= 16) return 1'b1;
    if (wr && RO[off / 4]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_read(input int d, input logic [31:0] addr);
    int idx;
    idx = int'((addr - BASE) / 4);
    if (RO[idx]) return hw_rdata[idx*32 +: 32];
    return mem[d][idx];
  endfunction

  task automatic xfer(input int d, input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                      output logic [31:0] rd, output bit er, output int cyc, output logic [15:0] pulse);
    bit done;
    rd = 32'h0; er = 1'b0; done = 1'b0;
    @(posedge pclk); #1;
    psel = 3'b000; psel[d] = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    @(negedge pclk); cyc = 1;
    chk("setup_no_ready", {pready_a[d], pslverr_a[d], prdata_a[d]}, 64'h0);
    @(posedge pclk); #1; penable = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge pclk); cyc++;
      if (pready_a[d]) begin
        done = 1'b1; rd = prdata_a[d]; er = pslverr_a[d];
      end else begin
        chk("wait_outs_zero", {pslverr_a[d], prdata_a[d]}, 64'h0);
        @(posedge pclk); #1;
      end
    end
    chk("pready_seen", done, 1'b1);
    @(posedge pclk); #1; psel = 3'b000; penable = 1'b0;
    @(negedge pclk); pulse = wr_pulse_a[d];
    @(negedge pclk); chk("pulse_one_cycle", wr_pulse_a[d], 16'h0);
  endtask

  typedef struct {
    int          d;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] rd, addr, wd;
  bit          er, wr;
  int          cyc, d;
  logic [15:0] pulse, exp_pulse;

  initial begin
    tbl = '{
      '{0, 32'h0000_100C, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0},
      '{0, 32'h0000_100C, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF},
      '{0, 32'h0000_1002, 1'b0, 32'h0,         1'b1, 32'h0},
      '{0, 32'h0000_1040, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0},
      '{0, 32'h0000_0FFC, 1'b0, 32'h0,         1'b1, 32'h0},
      '{0, 32'h0000_1008, 1'b1, 32'h55AA_55AA, 1'b1, 32'h0},
      '{0, 32'h0000_1008, 1'b0, 32'h0,         1'b0, 32'h1234_5678},
      '{1, 32'h0000_1000, 1'b0, 32'h0,         1'b0, 32'h0},
      '{1, 32'h0000_1000, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0},
      '{1, 32'h0000_1000, 1'b0, 32'h0,         1'b0, 32'h0BAD_F00D},
      '{2, 32'h0000_103C, 1'b1, 32'h8765_4321, 1'b0, 32'h0},
      '{2, 32'h0000_103C, 1'b0, 32'h0,         1'b0, 32'h8765_4321},
      '{0, 32'h0000_1002, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0}
    };
    for (int i = 0; i < 16; i++) hw_rdata[i*32 +: 32] = $urandom;
    hw_rdata[2*32 +: 32] = 32'h1234_5678;
    foreach (mem[i, j]) mem[i][j] = 32'h0;
    presetn = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_outs", {pready_a[i], pslverr_a[i], prdata_a[i], wr_pulse_a[i]}, 64'h0);
      chk("reset_regs", |regs_a[i], 1'b0);
    end

    // Directed vectors
    foreach (tbl[i]) begin
      xfer(tbl[i].d, tbl[i].addr, tbl[i].wr, tbl[i].wd, rd, er, cyc, pulse);
      exp_pulse = (tbl[i].wr && !tbl[i].err) ? (16'h1 << ((tbl[i].addr - BASE) >> 2)) : 16'h0;
      chk("tbl_err", er, tbl[i].err);
      chk("tbl_rdata", rd, tbl[i].rd);
      chk("tbl_cycles", cyc, ws[tbl[i].d] + 2);
      chk("tbl_pulse", pulse, exp_pulse);
      if (tbl[i].wr && !tbl[i].err) mem[tbl[i].d][(tbl[i].addr - BASE) >> 2] = tbl[i].wd;
    end

    // Abort on the 4-wait-state completer: psel dropped after two access cycles
    xfer(2, 32'h0000_1004, 1'b1, 32'h1111_1111, rd, er, cyc, pulse);
    mem[2][1] = 32'h1111_1111;
    @(posedge pclk); #1;
    psel = 3'b100; penable = 1'b0; paddr = 32'h0000_1004; pwrite = 1'b1; pwdata = 32'h2222_2222;
    @(posedge pclk); #1; penable = 1'b1;
    repeat (2) begin
      @(negedge pclk); chk("abort_wait_ready", pready_a[2], 1'b0);
      @(posedge pclk); #1;
    end
    psel = 3'b000; penable = 1'b0;
    repeat (6) begin
      @(negedge pclk); chk("abort_no_pulse", wr_pulse_a[2], 16'h0);
    end
    chk("abort_reg_kept", regs_a[2][1*32 +: 32], 32'h1111_1111);
    xfer(2, 32'h0000_1004, 1'b0, 32'h0, rd, er, cyc, pulse);
    chk("abort_readback", rd, 32'h1111_1111);

    // Back-to-back: read setup in the cycle right after the write completes
    @(posedge pclk); #1;
    psel = 3'b001; penable = 1'b0; paddr = 32'h0000_1010; pwrite = 1'b1; pwdata = 32'hA5A5_5A5A;
    @(posedge pclk); #1; penable = 1'b1;
    @(negedge pclk); chk("b2b_wr_ready", pready_a[0], 1'b1);
    @(posedge pclk); #1; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk); chk("b2b_pulse", wr_pulse_a[0], 16'h0010); chk("b2b_setup_ready", pready_a[0], 1'b0);
    @(posedge pclk); #1; penable = 1'b1;
    @(negedge pclk); chk("b2b_rd_ready", pready_a[0], 1'b1); chk("b2b_rdata", prdata_a[0], 32'hA5A5_5A5A);
    @(posedge pclk); #1; psel = 3'b000; penable = 1'b0;
    mem[0][4] = 32'hA5A5_5A5A;

    // Randomized traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      d = int'($urandom_range(0, 2));
      addr = 32'h0000_0FF0 + $urandom_range(0, 32'h60);
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      xfer(d, addr, wr, wd, rd, er, cyc, pulse);
      chk("rnd_err", er, ref_err(addr, wr));
      chk("rnd_rdata", rd, (!wr && !ref_err(addr, wr)) ? ref_read(d, addr) : 32'h0);
      chk("rnd_cycles", cyc, ws[d] + 2);
      exp_pulse = (wr && !ref_err(addr, wr)) ? (16'h1 << ((addr - BASE) >> 2)) : 16'h0;
      chk("rnd_pulse", pulse, exp_pulse);
      if (wr && !ref_err(addr, wr)) mem[d][(addr - BASE) >> 2] = wd;
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16; j++)
        chk("regs_o_contents", regs_a[i][j*32 +: 32], RO[j] ? 32'h0 : mem[i][j]);

    // Reset asserted while the 3-wait-state completer is waiting
    @(posedge pclk); #1;
    psel = 3'b010; penable = 1'b0; paddr = 32'h0000_1000; pwrite = 1'b0;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; presetn = 1'b0;
    @(negedge pclk);
    chk("rst_mid_ready", {pready_a[1], pslverr_a[1], prdata_a[1]}, 64'h0);
    for (int i = 0; i < 3; i++) chk("rst_mid_regs", {|regs_a[i], wr_pulse_a[i]}, 17'h0);
    psel = 3'b000; penable = 1'b0;
    @(posedge pclk); #1; presetn = 1'b1;
    foreach (mem[i, j]) mem[i][j] = 32'h0;
    xfer(0, 32'h0000_100C, 1'b0, 32'h0, rd, er, cyc, pulse);
    chk("post_rst_rdata", rd, 32'h0);
    xfer(1, 32'h0000_1004, 1'b1, 32'h0F0F_0F0F, rd, er, cyc, pulse);
    chk("post_rst_cycles", cyc, 5);
    chk("post_rst_pulse", pulse, 16'h0002);
    xfer(1, 32'h0000_1004, 1'b0, 32'h0, rd, er, cyc, pulse);
    chk("post_rst_readback", rd, 32'h0F0F_0F0F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
